alu_writeback_stage: RTL and testbench

- Pipeline stage directly downstream of the 16-bit ALU.
- Registers the ALU result and flag word together with the destination register address.
- Buffers them in a 2-entry skid buffer with a valid/ready handshake from the execute stage.
- Drives the register-file write port and updates the architectural status register (Z/N/C/V) in program order on retirement.

---
 rtl/alu_writeback_stage.sv | 125 ++++++++++++
 tb/tb_alu_writeback_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// Writeback stage after the 16-bit ALU: 2-entry skid buffer feeding the register-file write port.
// Retirement updates the status flags and the retire counter. ALU_WB_STICKY_OVF_EN adds a sticky overflow flag.
module alu_writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int FLAG_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [FLAG_W-1:0]     in_flags,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_wr_en,
    input  logic                  in_flag_we,
    input  logic                  rf_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [3:0]            status,
    output logic [15:0]           retire_cnt
`ifdef ALU_WB_STICKY_OVF_EN
    ,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr
`endif
);

    logic                  h_valid, s_valid;
    logic [DATA_W-1:0]     h_result, s_result;
    logic [3:0]            h_flags, s_flags;
    logic [REG_ADDR_W-1:0] h_dest, s_dest;
    logic                  h_wr_en, s_wr_en;
    logic                  h_flag_we, s_flag_we;

    logic accept;
    logic retire;

    // Only Z/N/C/V are carried through the stage.
    logic unused_flags;
    assign unused_flags = ^in_flags[FLAG_W-1:4];

    // in_ready comes straight from a flop, so it never depends on rf_stall.
    assign in_ready = ~s_valid;
    assign accept   = in_valid && in_ready;
    assign retire   = h_valid && !rf_stall;

    assign rf_we    = h_valid && h_wr_en && !rf_stall;
    assign rf_waddr = h_dest;
    assign rf_wdata = h_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_valid   <= 1'b0;
            h_result  <= '0;
            h_flags   <= '0;
            h_dest    <= '0;
            h_wr_en   <= 1'b0;
            h_flag_we <= 1'b0;
        end else if (retire && s_valid) begin
            h_valid   <= 1'b1;
            h_result  <= s_result;
            h_flags   <= s_flags;
            h_dest    <= s_dest;
            h_wr_en   <= s_wr_en;
            h_flag_we <= s_flag_we;
        end else if (accept && (retire || !h_valid)) begin
            h_valid   <= 1'b1;
            h_result  <= in_result;
            h_flags   <= in_flags[3:0];
            h_dest    <= in_dest;
            h_wr_en   <= in_wr_en;
            h_flag_we <= in_flag_we;
        end else if (retire) begin
            h_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid   <= 1'b0;
            s_result  <= '0;
            s_flags   <= '0;
            s_dest    <= '0;
            s_wr_en   <= 1'b0;
            s_flag_we <= 1'b0;
        end else if (accept && h_valid && (!retire || s_valid)) begin
            s_valid   <= 1'b1;
            s_result  <= in_result;
            s_flags   <= in_flags[3:0];
            s_dest    <= in_dest;
            s_wr_en   <= in_wr_en;
            s_flag_we <= in_flag_we;
        end else if (retire) begin
            s_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status     <= 4'b0000;
            retire_cnt <= 16'h0000;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 16'h0001;
            if (h_flag_we) begin
                status <= h_flags;
            end
        end
    end

`ifdef ALU_WB_STICKY_OVF_EN
    // A new overflow on the retire edge outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (retire && h_flag_we && h_flags[3]) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: expected register writes are queued at issue
// and checked by a monitor whenever rf_we is seen.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [15:0] in_flags;
    logic [2:0]  in_dest;
    logic        in_wr_en;
    logic        in_flag_we;
    logic        rf_stall;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  status;
    logic [15:0] retire_cnt;
`ifdef ALU_WB_STICKY_OVF_EN
    logic        ovf_sticky;
    logic        ovf_clr;
`endif

    int checks = 0;
    int errors = 0;
    int total_waits;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_dest    (in_dest),
        .in_wr_en   (in_wr_en),
        .in_flag_we (in_flag_we),
        .rf_stall   (rf_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .status     (status),
        .retire_cnt (retire_cnt)
`ifdef ALU_WB_STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_waddr, rf_wdata);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL rf_write: got addr %0d data %0h expected addr %0d data %0h",
                             rf_waddr, rf_wdata, e[18:16], e[15:0]);
                end
            end
        end
    end

    task automatic send(input logic [15:0] res, input logic [2:0] dst, input logic wr,
                        input logic fwe, input logic [15:0] fl, input logic push);
        int waits;
        in_result  = res;
        in_dest    = dst;
        in_wr_en   = wr;
        in_flag_we = fwe;
        in_flags   = fl;
        in_valid   = 1'b1;
        if (push && wr) exp_q.push_back({dst, res});
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        total_waits += waits;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_dest = '0;
        in_wr_en = 1'b0; in_flag_we = 1'b0; rf_stall = 1'b0;
`ifdef ALU_WB_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_waddr", rf_waddr, 0);
        chk("reset_wdata", rf_wdata, 0);
        chk("reset_status", status, 0);
        chk("reset_cnt", retire_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single op
        send(16'h1234, 3'd3, 1, 1, 16'h0000, 1);
        @(negedge clk);
        chk("t1_rf_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 3);
        chk("t1_wdata", rf_wdata, 16'h1234);
        @(posedge clk); #1;
        chk("t1_status", status, 0);
        chk("t1_cnt", retire_cnt, 1);

        // 2: back-to-back stream 1..8, flags follow the value
        total_waits = 0;
        for (int i = 1; i <= 8; i++)
            send(16'(i), 3'(i), 1, 1, 16'(i), 1);
        chk("t2_no_backpressure", total_waits, 0);
        @(posedge clk); #1;
        chk("t2_cnt", retire_cnt, 9);
        chk("t2_status", status, 4'b1000);

        // 3: stall with three entries, C must wait
        rf_stall = 1'b1;
        send(16'h00AA, 3'd1, 1, 0, 16'h0000, 1);
        send(16'h00BB, 3'd2, 1, 0, 16'h0000, 1);
        @(negedge clk);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_stall_we", rf_we, 0);
        chk("t3_head_data", rf_wdata, 16'h00AA);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_stall_cnt", retire_cnt, 9);
        rf_stall = 1'b0;
        total_waits = 0;
        send(16'h00CC, 3'd4, 1, 0, 16'h0000, 1);
        chk("t3_c_waited", total_waits, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_cnt", retire_cnt, 12);
        chk("t3_status_hold", status, 4'b1000);
        chk("t3_queue_drained", exp_q.size(), 0);

        // 4: compare-only op, upper flag bits are junk
        send(16'h5555, 3'd5, 0, 1, 16'hF0F1, 1);
        @(negedge clk);
        chk("t4_rf_we", rf_we, 0);
        @(posedge clk); #1;
        chk("t4_status", status, 4'b0001);
        chk("t4_cnt", retire_cnt, 13);

        // 5: async reset while full and stalled
        rf_stall = 1'b1;
        send(16'h0777, 3'd6, 1, 1, 16'h000F, 0);
        send(16'h0888, 3'd7, 1, 1, 16'h000F, 0);
        @(negedge clk);
        chk("t5_full", in_ready, 0);
        chk("t5_head_addr", rf_waddr, 6);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_we", rf_we, 0);
        chk("t5_rst_waddr", rf_waddr, 0);
        chk("t5_rst_wdata", rf_wdata, 0);
        chk("t5_rst_status", status, 0);
        chk("t5_rst_cnt", retire_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        rf_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_post_ready", in_ready, 1);
        chk("t5_post_cnt", retire_cnt, 0);
        @(posedge clk); #1;

`ifdef ALU_WB_STICKY_OVF_EN
        // 6: sticky overflow
        send(16'h0001, 3'd1, 1, 1, 16'h0008, 1);
        @(posedge clk); #1;
        chk("t6_set", ovf_sticky, 1);
        send(16'h0002, 3'd1, 1, 1, 16'h0000, 1);
        @(posedge clk); #1;
        chk("t6_hold", ovf_sticky, 1);
        send(16'h0003, 3'd1, 1, 1, 16'h0008, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("t6_set_wins", ovf_sticky, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("t6_clear", ovf_sticky, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
